// File: rtl/mmu_arbiter_pkg.sv
// mmu_arbiter_pkg
//   Shared types and defaults for the MMU request arbiter.
//   - ibus/dbus request and response structs as seen by the pipeline and MMU
//   - mmu_arb_state_t: arbiter state encoding
//   - STARVE_LIMIT_DEFAULT / FLUSH_CYCLES_DEFAULT: parameter defaults
package mmu_arbiter_pkg;

    localparam int STARVE_LIMIT_DEFAULT = 4;
    localparam int FLUSH_CYCLES_DEFAULT = 2;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        WAIT_I  = 3'd3,
        WAIT_D  = 3'd4,
        FLUSH   = 3'd5
    } mmu_arb_state_t;

endpackage

// File: rtl/mmu_arbiter_sat_counter.sv
// sat_counter
//   Up-counter that sticks at MAX. Clear has priority over increment.
//   Ports:
//     clk, reset : clock, synchronous active-high reset (count -> 0)
//     clr        : synchronous clear
//     inc        : increment request (ignored once count == MAX)
//     count      : current value
module sat_counter #(
    parameter int W   = 3,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != MAX_V)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mmu_arbiter.sv
// mmu_arbiter
//   Serialises fetch and memory-stage requests onto the single MMU walker
//   and sequences walker flushes so they only happen between translations.
//   Data requests win unless fetch has waited through STARVE_LIMIT
//   consecutive data grants.
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     ireq / dreq       : core fetch / memory-stage requests
//     flush_req         : one-cycle flush request pulse
//     iresp / dresp     : responses routed back to the core
//     i_page_fault      : fault pulse to fetch
//     d_page_fault      : fault pulse to memory stage
//     flush_done        : one-cycle pulse in the last FLUSH cycle
//     busy              : arbiter not in IDLE
//     mmu_ireq/mmu_dreq : latched request presented to the MMU
//     mmu_iresp/mmu_dresp, mmu_page_fault : MMU responses
module mmu_arbiter
    import mmu_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    input  dbus_req_t  dreq,
    input  logic       flush_req,
    output ibus_resp_t iresp,
    output dbus_resp_t dresp,
    output logic       i_page_fault,
    output logic       d_page_fault,
    output logic       flush_done,
    output logic       busy,
    output ibus_req_t  mmu_ireq,
    output dbus_req_t  mmu_dreq,
    input  ibus_resp_t mmu_iresp,
    input  dbus_resp_t mmu_dresp,
    input  logic       mmu_page_fault
);

    localparam int SW = 3;
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    mmu_arb_state_t state_q, state_d;
    ibus_req_t      ireq_q;
    dbus_req_t      dreq_q;
    logic           flush_pend_q;
    logic [SW-1:0]  starve_cnt;
    logic [FW-1:0]  flush_cnt;
    logic           grant_i, grant_d, flush_start, flush_last;

    assign flush_last = (state_q == FLUSH) && (flush_cnt == FLUSH_LAST);
    assign busy       = (state_q != IDLE);

    // Consecutive data grants made while fetch was waiting.
    sat_counter #(.W(SW), .MAX(STARVE_LIMIT)) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (grant_i | (grant_d & ~ireq.valid)),
        .inc   (grant_d & ireq.valid),
        .count (starve_cnt)
    );

    // Cycles spent in FLUSH; restarted on every entry.
    sat_counter #(.W(FW), .MAX(FLUSH_CYCLES)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (flush_start),
        .inc   (state_q == FLUSH),
        .count (flush_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ireq_q       <= '0;
            dreq_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_i) ireq_q <= ireq;
            if (grant_d) dreq_q <= dreq;
            // A flush requested mid-translation waits for the next IDLE;
            // one arriving during FLUSH is covered by the flush in progress.
            if (flush_last) begin
                flush_pend_q <= 1'b0;
            end else if (flush_req && (state_q != IDLE) && (state_q != FLUSH)) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        flush_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush_pend_q || flush_req) begin
                    state_d     = FLUSH;
                    flush_start = 1'b1;
                end else if (dreq.valid && !(ireq.valid && (starve_cnt == STARVE_MAX))) begin
                    state_d = GRANT_D;
                    grant_d = 1'b1;
                end else if (ireq.valid) begin
                    state_d = GRANT_I;
                    grant_i = 1'b1;
                end
            end
            GRANT_I: begin
                if (mmu_page_fault || mmu_iresp.data_ok) state_d = IDLE;
                else if (mmu_iresp.addr_ok)              state_d = WAIT_I;
            end
            WAIT_I: begin
                if (mmu_page_fault || mmu_iresp.data_ok) state_d = IDLE;
            end
            GRANT_D: begin
                if (mmu_page_fault || mmu_dresp.data_ok) state_d = IDLE;
                else if (mmu_dresp.addr_ok)              state_d = WAIT_D;
            end
            WAIT_D: begin
                if (mmu_page_fault || mmu_dresp.data_ok) state_d = IDLE;
            end
            FLUSH: begin
                if (flush_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Only the granted side sees MMU traffic; a fault suppresses data_ok.
    always_comb begin
        mmu_ireq     = '0;
        mmu_dreq     = '0;
        iresp        = '0;
        dresp        = '0;
        i_page_fault = 1'b0;
        d_page_fault = 1'b0;
        flush_done   = 1'b0;
        unique case (state_q)
            GRANT_I, WAIT_I: begin
                if (state_q == GRANT_I) begin
                    mmu_ireq       = ireq_q;
                    mmu_ireq.valid = 1'b1;
                end
                iresp = mmu_iresp;
                if (mmu_page_fault) begin
                    iresp.data_ok = 1'b0;
                    i_page_fault  = 1'b1;
                end
            end
            GRANT_D, WAIT_D: begin
                if (state_q == GRANT_D) begin
                    mmu_dreq       = dreq_q;
                    mmu_dreq.valid = 1'b1;
                end
                dresp = mmu_dresp;
                if (mmu_page_fault) begin
                    dresp.data_ok = 1'b0;
                    d_page_fault  = 1'b1;
                end
            end
            FLUSH: begin
                flush_done = flush_last;
            end
            default: begin
                flush_done = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mmu_arbiter.md
# mmu_arbiter

Serialises fetch and memory-stage requests onto the single translation walker, so at most one of `mmu_ireq`/`mmu_dreq` is valid at any time. Data requests win by default; a starvation counter guarantees fetch progress. The block also sequences TLB/walker flushes (`sfence.vma`, satp writes) so they occur only between translations. It sits between the pipeline's ibus/dbus ports and the MMU.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch waits; the next grant goes to fetch.
- `FLUSH_CYCLES`, 2: cycles spent in FLUSH before `flush_done`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `ireq` in `ibus_req_t`: fetch request, held by core until `iresp.data_ok`.
- `dreq` in `dbus_req_t`: memory-stage request, held until `dresp.data_ok`.
- `flush_req` in 1: one-cycle pulse requesting a walker flush.
- `iresp` out `ibus_resp_t`: response to fetch.
- `dresp` out `dbus_resp_t`: response to memory stage.
- `i_page_fault` out 1: one-cycle fault pulse to fetch.
- `d_page_fault` out 1: one-cycle fault pulse to memory stage.
- `flush_done` out 1: one-cycle pulse when the flush completes.
- `busy` out 1: state is not IDLE.
- `mmu_ireq` out `ibus_req_t`: to MMU.
- `mmu_dreq` out `dbus_req_t`: to MMU.
- `mmu_iresp` in `ibus_resp_t`: from MMU.
- `mmu_dresp` in `dbus_resp_t`: from MMU.
- `mmu_page_fault` in 1: from MMU.

## Operation
- **States.**
  - IDLE: no grant outstanding.
  - GRANT_I / GRANT_D: request sent to MMU, waiting for `addr_ok`.
  - WAIT_I / WAIT_D: `addr_ok` seen, waiting for `data_ok`.
  - FLUSH: flush in progress.
- **IDLE decision, in priority order:**
  1. Flush pending, or `flush_req` asserted → FLUSH.
  2. `dreq.valid` and not (`ireq.valid` and `starve_cnt == STARVE_LIMIT`) → GRANT_D.
  3. `ireq.valid` → GRANT_I.
- **Latching.** On grant, the winning request is latched into `req_q`. The MMU sees only `req_q`; later changes on the core side are ignored until completion.
- **GRANT_x.** Drive `mmu_xreq = req_q` with `valid = 1`. On `mmu_xresp.addr_ok` → WAIT_x and deassert valid the next cycle.
- **Completion.** If `mmu_xresp.data_ok` arrives in GRANT_x or WAIT_x → IDLE.
- **Fault.** If `mmu_page_fault` is seen in GRANT_x or WAIT_x before `data_ok`: pulse `x_page_fault` for one cycle, suppress `data_ok` toward the core, and go → IDLE. If fault and `data_ok` arrive in the same cycle, the fault wins.
- **Response routing.** The `mmu_xresp` fields pass combinationally to the granted requester only. The non-granted response is all zero. In IDLE and FLUSH both responses are zero.
- **Starvation counter `starve_cnt`** (3 bits, saturating at `STARVE_LIMIT`):
  - +1 on each data grant while `ireq.valid`.
  - Cleared on any fetch grant, or on a data grant while `ireq.valid == 0`.
- **Flush sequencing.**
  - A `flush_req` that arrives while not in IDLE sets `flush_pend`.
  - The flush is taken at the next IDLE, ahead of any grant.
  - FLUSH counts `FLUSH_CYCLES` cycles, then pulses `flush_done`, clears `flush_pend` and returns → IDLE.
  - A `flush_req` arriving during FLUSH is absorbed; no second flush is run.
- **Withdrawal.** A request dropped before grant is ignored. A request dropped after grant still completes; its response is driven regardless.

## Timing
- **Reset values:** state IDLE; all outputs 0; `starve_cnt`, `flush_pend` and `req_q` cleared.
- **Reset mid-operation** discards the grant. The MMU sees `valid = 0` on the next cycle.
- **Grant latency:** a request seen in IDLE at edge N has `mmu_xreq.valid = 1` during cycle N+1. `addr_ok` and `data_ok` reach the core in the same cycle they arrive (zero added latency).
- **Back-to-back:** the earliest next grant is 1 cycle after `data_ok`. There is one IDLE cycle per transaction.
- **Flush:** `flush_req` in IDLE at edge N gives `flush_done` during cycle N+`FLUSH_CYCLES`.
- **Invariant:** `mmu_ireq.valid & mmu_dreq.valid` is never 1.

## Structure
- `mmu_arb_state_t` (6-state enum) goes in `common`.
- `STARVE_LIMIT_DEFAULT` and `FLUSH_CYCLES_DEFAULT` go in `config_pkg`.
- One natural sub-module: `sat_counter`, a parameterised saturating counter used for both `starve_cnt` and the flush counter.
- Everything else is flat: one `always_ff` for state/registers, one `always_comb` for next state, one `always_comb` for routing.

## Test plan
- **Data priority:** `ireq` (addr `0x8000_0000`) and `dreq` (addr `0x8000_1000`) asserted together in IDLE → `mmu_dreq.valid` in cycle +1, `mmu_ireq.valid = 0`. Fetch is granted only after `dresp.data_ok`.
- **Starvation:** `ireq` held, with 5 consecutive `dreq`s → grants D,D,D,D,I. Fetch gets the 5th grant and `starve_cnt` returns to 0.
- **Fault:** `dreq` granted, `mmu_page_fault = 1` two cycles after `addr_ok` → `d_page_fault` pulses once, `dresp.data_ok` stays 0, `busy = 0` next cycle.
- **Flush while busy:** `flush_req` pulsed during WAIT_I → the fetch completes with `iresp.data_ok`. FLUSH starts the next cycle even though `dreq` is valid, `flush_done` follows 2 cycles later, and only then `dreq` is granted.
- **Reset mid-op:** `reset` asserted in GRANT_D → next cycle every output is 0 and state is IDLE. The request is re-granted after `reset` is released.
- **Hold/latch:** core changes `dreq.addr` from `0x1000` to `0x2000` after grant → `mmu_dreq.addr` stays `0x1000` until completion.
